// File: rtl/exec_pkg.sv
// exec_datapath shared definitions
// opcodes, mux Y codes, FSM states
package exec_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_OR    = 4'b0010;
  localparam logic [3:0] OP_AND   = 4'b0011;
  localparam logic [3:0] OP_DIV   = 4'b0100;
  localparam logic [3:0] OP_MUL   = 4'b0101;
  localparam logic [3:0] OP_PASSB = 4'b0110;

  localparam logic [1:0] YS_LO  = 2'b00;
  localparam logic [1:0] YS_HI  = 2'b01;
  localparam logic [1:0] YS_MEM = 2'b10;
  localparam logic [1:0] YS_RET = 2'b11;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_EXEC = 3'd1;
  localparam logic [2:0] ST_ITER = 3'd2;
  localparam logic [2:0] ST_WB   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // one radix-2 step per operand bit
  function automatic int iter_cycles(input int w);
    return w;
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative signed multiply / restoring divide
// Magnitude loop with sign fix-up on the last step
module iter_muldiv
  import exec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             iClk,
  input  logic             nRst,
  input  logic             iStart,
  input  logic             iDiv,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oDone,
  output logic [WIDTH-1:0] oHi,
  output logic [WIDTH-1:0] oLo,
  output logic             oDivZero
);

  logic             r_busy;
  logic             r_div;
  logic             r_sa;
  logic             r_sb;
  logic             r_dz;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mq;
  logic [WIDTH-1:0] r_md;

  logic [WIDTH-1:0]   w_ma;
  logic [WIDTH-1:0]   w_mb;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_t;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_acc_n;
  logic [WIDTH-1:0]   w_mq_n;
  logic [2*WIDTH-1:0] w_prod;

  assign w_ma = iA[WIDTH-1] ? -iA : iA;
  assign w_mb = iB[WIDTH-1] ? -iB : iB;

  // load magnitudes on start, then one step per cycle
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      r_busy <= 1'b0;
      r_div  <= 1'b0;
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_dz   <= 1'b0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_mq   <= '0;
      r_md   <= '0;
    end else if (iStart) begin
      r_busy <= 1'b1;
      r_div  <= iDiv;
      r_sa   <= iA[WIDTH-1];
      r_sb   <= iB[WIDTH-1];
      r_dz   <= iDiv && (iB == '0);
      r_cnt  <= CW'(iter_cycles(WIDTH) - 1);
      r_acc  <= '0;
      r_mq   <= w_ma;
      r_md   <= w_mb;
    end else if (r_busy) begin
      if (oDone) begin
        r_busy <= 1'b0;
      end else begin
        r_acc <= w_acc_n;
        r_mq  <= w_mq_n;
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // one shift-add or restoring-subtract step
  always_comb begin
    w_sum  = {1'b0, r_acc} + {1'b0, r_md};
    w_t    = {r_acc, r_mq[WIDTH-1]};
    w_diff = w_t - {1'b0, r_md};
    if (r_div) begin
      if (!w_diff[WIDTH]) begin
        w_acc_n = w_diff[WIDTH-1:0];
        w_mq_n  = {r_mq[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_n = w_t[WIDTH-1:0];
        w_mq_n  = {r_mq[WIDTH-2:0], 1'b0};
      end
    end else if (r_mq[0]) begin
      {w_acc_n, w_mq_n} = {w_sum, r_mq[WIDTH-1:1]};
    end else begin
      {w_acc_n, w_mq_n} = {1'b0, r_acc, r_mq[WIDTH-1:1]};
    end
  end

  assign w_prod = {w_acc_n, w_mq_n};

  // sign fix-up of the final step
  always_comb begin
    if (r_dz) begin
      oLo = '1;
      oHi = r_sa ? -r_mq : r_mq;
    end else if (r_div) begin
      oLo = (r_sa ^ r_sb) ? -w_mq_n : w_mq_n;
      oHi = r_sa ? -w_acc_n : w_acc_n;
    end else begin
      {oHi, oLo} = (r_sa ^ r_sb) ? -w_prod : w_prod;
    end
  end

  assign oDone    = r_busy && (r_dz || (r_cnt == '0));
  assign oDivZero = r_dz;

endmodule

// File: rtl/exec_datapath.sv
// Operand / ALU / result datapath
// RA/RB/RM latch, ALU, mul/div, RZ and RY
module exec_datapath
  import exec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 4,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             iClk,
  input  logic             nRst,
  input  logic             iValid,
  output logic             oReady,
  input  logic [OPW-1:0]   iOp,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic [WIDTH-1:0] iImm,
  input  logic             iBSel,
  input  logic [1:0]       iYSel,
  input  logic [WIDTH-1:0] iMemData,
  input  logic [WIDTH-1:0] iRetAddr,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oY,
  output logic [WIDTH-1:0] oStoreData,
  output logic             oZ,
  output logic             oN,
  output logic             oDivZero
);

  localparam logic [OPW-1:0] L_ADD = OPW'(OP_ADD);
  localparam logic [OPW-1:0] L_SUB = OPW'(OP_SUB);
  localparam logic [OPW-1:0] L_OR  = OPW'(OP_OR);
  localparam logic [OPW-1:0] L_AND = OPW'(OP_AND);
  localparam logic [OPW-1:0] L_DIV = OPW'(OP_DIV);
  localparam logic [OPW-1:0] L_MUL = OPW'(OP_MUL);

  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_y;
  logic [OPW-1:0]   r_op;
  logic [1:0]       r_ysel;
  logic             r_z;
  logic             r_n;
  logic             r_divzero;

  logic             w_acc;
  logic             w_long;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_y;
  logic             w_done;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic             w_dz;

  assign oReady = (r_state == ST_IDLE);
  assign oValid = (r_state == ST_DONE);
  assign w_acc  = iValid && oReady;
  assign w_long = (iOp == L_MUL) || (iOp == L_DIV);
  assign w_b    = iBSel ? iImm : iB;

  iter_muldiv #(
    .WIDTH(WIDTH),
    .CW   (CW)
  ) u_iter (
    .iClk    (iClk),
    .nRst    (nRst),
    .iStart  (w_acc && w_long),
    .iDiv    (iOp == L_DIV),
    .iA      (iA),
    .iB      (w_b),
    .oDone   (w_done),
    .oHi     (w_hi),
    .oLo     (w_lo),
    .oDivZero(w_dz)
  );

  // operation sequencing
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_acc) r_state <= w_long ? ST_ITER : ST_EXEC;
        ST_EXEC: r_state <= ST_WB;
        ST_ITER: if (w_done) r_state <= ST_WB;
        ST_WB:   r_state <= ST_DONE;
        ST_DONE: if (iReady) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // operand latch, RZ load, RY and flag update
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_m       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_y       <= '0;
      r_op      <= '0;
      r_ysel    <= '0;
      r_z       <= 1'b1;
      r_n       <= 1'b0;
      r_divzero <= 1'b0;
    end else begin
      if (w_acc) begin
        r_a    <= iA;
        r_b    <= w_b;
        r_m    <= iB;
        r_op   <= iOp;
        r_ysel <= iYSel;
      end
      if (r_state == ST_EXEC) begin
        r_lo <= w_alu;
        r_hi <= '0;
      end
      if ((r_state == ST_ITER) && w_done) begin
        r_lo <= w_lo;
        r_hi <= w_hi;
        if (r_op == L_DIV) r_divzero <= w_dz;
      end
      if (r_state == ST_WB) begin
        r_y <= w_y;
        r_z <= (r_lo == '0);
        r_n <= r_lo[WIDTH-1];
      end
    end
  end

  // single-cycle ALU; unknown codes pass B
  always_comb begin
    case (r_op)
      L_ADD:   w_alu = r_a + r_b;
      L_SUB:   w_alu = r_a - r_b;
      L_OR:    w_alu = r_a | r_b;
      L_AND:   w_alu = r_a & r_b;
      default: w_alu = r_b;
    endcase
  end

  // mux Y
  always_comb begin
    case (r_ysel)
      YS_LO:   w_y = r_lo;
      YS_HI:   w_y = r_hi;
      YS_MEM:  w_y = iMemData;
      default: w_y = iRetAddr;
    endcase
  end

  assign oY         = r_y;
  assign oStoreData = r_m;
  assign oZ         = r_z;
  assign oN         = r_n;
  assign oDivZero   = r_divzero;

endmodule

// File: doc/exec_datapath.md
Name: exec_datapath

Overview:
- Parametrised successor to the fixed 32-bit MiniSRC operand/ALU/result datapath.
- Latches operands into RA/RB, selects B (register or immediate), and computes into RZ (HI/LO). Selects the result into RY through mux Y.
- Adds iterative signed multiply/divide, a valid/ready handshake on both sides, condition flags and divide-by-zero detection.
- Sits between register-file read and write-back in the multicycle core.

Parameters:
- WIDTH, 32: datapath width in bits; must be even and ≥ 8.
- OPW, 4: opcode field width.
- CW, $clog2(WIDTH)+1: iteration counter width (derived; do not override).

Ports:
- iClk, in, 1: clock; all state updates on the rising edge.
- nRst, in, 1: reset, asynchronous, active-low.
- iValid, in, 1: upstream operation valid.
- oReady, out, 1: block can accept an operation.
- iOp, in, OPW: operation. 0000 ADD, 0001 SUB, 0010 OR, 0011 AND, 0100 DIV, 0101 MUL, 0110 PASSB. Any other code is treated as PASSB.
- iA, in, WIDTH: operand A (register-file port A).
- iB, in, WIDTH: operand B (register-file port B).
- iImm, in, WIDTH: sign-extended immediate.
- iBSel, in, 1: mux B select. 0 selects RB; 1 selects iImm.
- iYSel, in, 2: mux Y select. 00 LO, 01 HI, 10 iMemData, 11 iRetAddr.
- iMemData, in, WIDTH: memory read data.
- iRetAddr, in, WIDTH: return address.
- oValid, out, 1: result valid.
- iReady, in, 1: downstream accepts the result.
- oY, out, WIDTH: RY register contents.
- oStoreData, out, WIDTH: RM register (RB copy, loaded at accept).
- oZ, out, 1: LO == 0.
- oN, out, 1: LO MSB.
- oDivZero, out, 1: the last DIV had divisor 0.

Behaviour:
- Reset (nRst low, asynchronous): state IDLE; RA, RB, RM, RZ_HI, RZ_LO, RY, counter = 0; oValid = 0, oReady = 1 after release, oZ = 1, oN = 0, oDivZero = 0.
- Accept: iValid && oReady at edge k.
  - RA ← iA.
  - RB ← (iBSel ? iImm : iB).
  - RM ← iB.
  - iOp and iYSel are captured.
  - oReady = (state == IDLE) only.
- FSM states: IDLE, EXEC, ITER, WB, DONE.
- IDLE: on accept, go to ITER if the op is MUL/DIV, otherwise EXEC.
- EXEC:
  - RZ_LO ← result; RZ_HI ← 0.
  - ADD/SUB use two's-complement wraparound; carry is discarded.
  - Go to WB.
- ITER:
  - Runs exactly WIDTH cycles (counter WIDTH-1 down to 0) on operand magnitudes.
  - MUL: radix-2 shift-add.
  - DIV: restoring division.
  - On the final cycle, apply the sign correction and load RZ, then go to WB.
  - MUL: {HI,LO} = signed 2·WIDTH-bit product.
  - DIV: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - DIV with divisor 0: skip iteration (go straight to WB), LO = all ones, HI = dividend, oDivZero ← 1.
  - Any other DIV clears oDivZero. Non-DIV ops leave oDivZero unchanged.
- WB:
  - RY ← mux Y(iYSel): LO, HI, iMemData or iRetAddr. iMemData and iRetAddr are sampled at this edge.
  - oZ and oN update from LO.
  - Go to DONE.
- DONE:
  - oValid = 1; oY, flags and RM are held stable.
  - On iReady, go to IDLE (oValid drops next cycle).
  - Back-to-back ops are not allowed: at least 1 idle cycle with oReady = 1 precedes the next accept.
- Latency from accept edge to oValid high:
  - single-cycle ops: 3 edges (EXEC, WB, DONE entry).
  - MUL/DIV: WIDTH+2 edges.
  - DIV by 0: 3 edges.
- iValid while busy is ignored (no accept). Inputs other than iMemData and iRetAddr are don't-care outside the accept cycle.
- Reset mid-ITER or mid-DONE aborts immediately; the partial result is discarded and oValid = 0.

Decomposition:
- Package exec_pkg holds:
  - opcode localparams;
  - mux Y select codes;
  - FSM state enum;
  - iteration-count constant.
- Sub-module iter_muldiv (parameter WIDTH) owns the magnitude conversion, shift-add/restoring loop, counter, sign fix-up and div-zero detect. Its interface is start/done plus the HI/LO outputs.
- The top level holds RA, RB, RM, RZ, RY, mux B, mux Y, the single-cycle ALU and the FSM.

Test Plan (WIDTH = 32):
- ADD with iA = 5, iB = 7, iBSel = 0, iYSel = 00 → oY = 0x0000000C, oZ = 0, oN = 0; oValid exactly 3 edges after accept.
- SUB with iA = 3, iImm = 5, iBSel = 1 → oY = 0xFFFFFFFE, oN = 1. Then AND with iA = 0xF0, iB = 0x0F → oY = 0, oZ = 1.
- MUL with iA = -3, iB = 7:
  - iYSel = 00 → oY = 0xFFFFFFEB;
  - repeat with iYSel = 01 → oY = 0xFFFFFFFF;
  - oValid 34 edges after accept; oReady = 0 throughout.
- DIV -7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF, oDivZero = 0. DIV 9 / 0 → LO = 0xFFFFFFFF, HI = 9, oDivZero = 1, latency 3.
- Backpressure: hold iReady = 0 for 10 cycles in DONE → oValid and oY stable, oReady = 0, iValid pulses ignored. Release → exactly one transfer.
- Assert nRst at ITER cycle 10 of a MUL → all outputs at reset values immediately. After release, ADD 1+1 → oY = 2.
